// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: buffers host TX words in a FIFO, launches one SPI
// master transfer per word, and collects the received words in an RX FIFO.
// A transfer only starts when the RX FIFO has room for its result.
module spi_xfer_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_tx_data,
  input  logic                          spi_busy,
  input  logic [DATA_WIDTH-1:0]         spi_rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [15:0]                   xfer_count,
  output logic                          seq_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CAPTURE   = 3'd4;

  logic [2:0] state, state_nxt;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wptr, tx_rptr;
  logic [LW-1:0]         tx_lvl;
  logic                  tx_full, tx_empty, tx_push, tx_pop;

  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         rx_wptr, rx_rptr;
  logic [LW-1:0]         rx_lvl;
  logic                  rx_full, rx_empty, rx_push, rx_pop;

  logic                  load;

  assign tx_full  = (tx_lvl == LVL_FULL);
  assign tx_empty = (tx_lvl == '0);
  assign rx_full  = (rx_lvl == LVL_FULL);
  assign rx_empty = (rx_lvl == '0);

  // Reserving the RX slot before launching means CAPTURE can never overflow.
  assign load    = (state == S_IDLE) && !tx_empty && !rx_full;
  assign tx_push = wr_valid && !tx_full;
  assign tx_pop  = load;
  assign rx_push = (state == S_CAPTURE) && !rx_full;
  assign rx_pop  = rd_ready && !rx_empty;

  assign wr_ready  = !tx_full;
  assign rd_valid  = !rx_empty;
  assign rd_data   = rx_mem[rx_rptr];
  assign tx_level  = tx_lvl;
  assign spi_start = (state == S_LAUNCH);
  assign seq_idle  = (state == S_IDLE);

  // TX storage write port.
  // NOTE: FIFO storage has no reset; the level counter alone defines validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= wr_data;
  end

  // TX pointers and occupancy; simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_lvl  <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_lvl <= tx_lvl + LVL_ONE;
        2'b01:   tx_lvl <= tx_lvl - LVL_ONE;
        default: ;
      endcase
    end
  end

  // RX storage write port, fed from the master in CAPTURE.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= spi_rx_data;
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_lvl  <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_lvl <= rx_lvl + LVL_ONE;
        2'b01:   rx_lvl <= rx_lvl - LVL_ONE;
        default: ;
      endcase
    end
  end

  // Next-state logic for the transfer handshake with the master.
  always_comb begin
    // NOTE: assigning a default first keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      S_IDLE:      if (load) state_nxt = S_LAUNCH;
      S_LAUNCH:    state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (spi_busy) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!spi_busy) state_nxt = S_CAPTURE;
      S_CAPTURE:   state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register, held word for the master, and completed-transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state       <= S_IDLE;
      spi_tx_data <= '0;
      xfer_count  <= '0;
    end else begin
      state <= state_nxt;
      if (load)                 spi_tx_data <= tx_mem[tx_rptr];
      if (state == S_CAPTURE)   xfer_count  <= xfer_count + 16'd1;
    end
  end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the SPI word width.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set TX and RX FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-003 clk  in  1  SHALL be the system clock; all logic is rising-edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 wr_valid  in  1  SHALL indicate that the host TX word is valid.
REQ-006 wr_ready  out  1  SHALL equal !tx_full.
REQ-007 wr_data  in  DATA_WIDTH  SHALL carry the host TX word.
REQ-008 rd_valid  out  1  SHALL equal !rx_empty.
REQ-009 rd_ready  in  1  SHALL indicate that the host accepts the RX word.
REQ-010 rd_data  out  DATA_WIDTH  SHALL present the RX FIFO head combinationally.
REQ-011 spi_start  out  1  SHALL be the start pulse to the SPI master.
REQ-012 spi_tx_data  out  DATA_WIDTH  SHALL be the registered word presented to the master.
REQ-013 spi_busy  in  1  SHALL be the master busy flag.
REQ-014 spi_rx_data  in  DATA_WIDTH  SHALL be the master's received word.
REQ-015 tx_level  out  $clog2(FIFO_DEPTH)+1  SHALL give the TX FIFO occupancy.
REQ-016 xfer_count  out  16  SHALL count completed transfers.
REQ-017 seq_idle  out  1  SHALL be high when the FSM is in IDLE.

Function
REQ-018 A TX push SHALL occur when wr_valid && wr_ready; an RX pop SHALL occur when rd_valid && rd_ready.
REQ-019 Each FIFO SHALL be a circular buffer with wrapping pointers and a level counter; a simultaneous push and pop SHALL leave the level unchanged.
REQ-020 A push to a full FIFO and a pop from an empty FIFO SHALL be ignored without corrupting data or level.
REQ-021 The FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and CAPTURE.
REQ-022 IDLE SHALL go to LAUNCH when the TX FIFO is non-empty and the RX FIFO is not full; on that edge the TX head SHALL be loaded into spi_tx_data and popped.
REQ-023 LAUNCH SHALL assert spi_start for exactly one cycle, then go to WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle in which spi_busy=1.
REQ-025 WAIT_DONE SHALL go to CAPTURE on the first cycle in which spi_busy=0.
REQ-026 In CAPTURE, spi_rx_data SHALL be pushed into the RX FIFO, xfer_count SHALL increment (wrapping 0xFFFF->0), and the FSM SHALL return to IDLE.
REQ-027 The RX-not-full gate in REQ-022 SHALL guarantee that the CAPTURE push never overflows the RX FIFO.
REQ-028 spi_tx_data SHALL hold constant from LAUNCH until the next IDLE->LAUNCH load.
REQ-029 The minimum spacing between spi_start pulses SHALL be the master's transfer length plus 3 cycles; back-to-back words SHALL never start while spi_busy=1.
REQ-030 Host pushes and pops SHALL be accepted in every FSM state.
REQ-031 Word order SHALL be preserved end to end: RX word n SHALL correspond to TX word n.

Reset
REQ-032 While rst_n=0: FSM=IDLE, both FIFOs empty and pointers 0, spi_start=0, spi_tx_data=0, xfer_count=0, tx_level=0, wr_ready=1, rd_valid=0, seq_idle=1.
REQ-033 Reset asserted mid-transfer SHALL discard the word in flight and all FIFO contents; no CAPTURE push SHALL occur.

Verification
REQ-034 Reset, then push 0xA5 against a loopback master model returning 0x3C -> one spi_start pulse, spi_tx_data=0xA5, rd_data=0x3C, xfer_count=1.
REQ-035 Push 4 words 0x01..0x04 with rd_ready=0 -> exactly 4 transfers, rd_valid=1 with 4 RX entries, then no further spi_start; wr_ready=1 again.
REQ-036 Push a 5th word with the RX FIFO full -> no spi_start until one pop; then the 5th transfer runs and RX order is 0x02..0x05.
REQ-037 Fill the TX FIFO (tx_level=4) and keep wr_valid=1 -> wr_ready=0 and the extra word is dropped; a simultaneous push and pop at level 2 keeps level 2.
REQ-038 Hold spi_busy high for 20 cycles -> FSM stays in WAIT_DONE, with no spi_start and no capture until spi_busy falls.
REQ-039 Assert rst_n=0 during WAIT_DONE -> all outputs at the REQ-032 values next cycle, and xfer_count is not incremented.
